// File: rtl/gat_feat_reader_if.sv
// Feature BRAM read port plus outbound beat stream between the reader and its neighbours.
interface gat_feat_reader_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W+1:0] feat_bram_addrb;
    logic [31:0]       feat_bram_dout;
    logic [31:0]       m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;

    modport master (
        output feat_bram_addrb,
        input  feat_bram_dout,
        output m_tdata,
        output m_tvalid,
        input  m_tready,
        output m_tlast
    );

    modport slave (
        input  feat_bram_addrb,
        output feat_bram_dout,
        input  m_tdata,
        input  m_tvalid,
        output m_tready,
        input  m_tlast
    );
endinterface

// File: rtl/gat_feat_reader.sv
// Walks the GAT new-feature BRAM once the layer is ready and streams the frame as
// 32-bit beats (four 8-bit features each), reads throttled by output FIFO credit.
module gat_feat_reader #(
    parameter int unsigned NUM_SUBGRAPHS      = 2708,
    parameter int unsigned NUM_FEATURE_OUT    = 16,
    parameter int unsigned DATA_WIDTH         = 8,
    parameter int unsigned NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int unsigned NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int unsigned OUT_FIFO_DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gat_ready,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    gat_feat_reader_if.master     bus
);
    localparam int unsigned IDX_W    = NEW_FEATURE_ADDR_W;
    localparam int unsigned PTR_W    = $clog2(OUT_FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned ENTRY_W  = 33;
    localparam int unsigned LAST_IDX = NEW_FEATURE_DEPTH - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_READ,
        S_DRAIN
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 rd_inflight_q, rd_inflight_d;
    logic                 rd_last_q, rd_last_d;
    logic [1:0]           lane_q, lane_d;
    logic [23:0]          pack_q, pack_d;
    logic [ENTRY_W-1:0]   mem_q [OUT_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     fifo_count_q, fifo_count_d;
    logic                 tvalid_q, tvalid_d;
    logic [31:0]          tdata_q;
    logic                 tlast_q;
    logic [ENTRY_W-1:0]   head_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 pop;
    logic                 push;
    logic                 pend;
    logic                 issue;
    logic [CNT_W:0]       credit_sum;
    logic [7:0]           ret_byte;
    logic [ENTRY_W-1:0]   push_word;
    logic                 unused_dout_hi;

    assign unused_dout_hi = ^bus.feat_bram_dout[31:DATA_WIDTH];

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        lane_d        = lane_q;
        pack_d        = pack_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        head_d        = {tlast_q, tdata_q};
        done_d        = 1'b0;
        pop           = tvalid_q && bus.m_tready;
        pend          = (lane_q != 2'd0) || rd_inflight_q;
        credit_sum    = {1'b0, fifo_count_q} + (CNT_W+1)'(pend);
        issue         = (state_q == S_READ) && (credit_sum < (CNT_W+1)'(OUT_FIFO_DEPTH));
        rd_inflight_d = issue;
        rd_last_d     = issue && (idx_q == IDX_W'(LAST_IDX));
        ret_byte      = bus.feat_bram_dout[7:0];
        push          = rd_inflight_q && (lane_q == 2'd3);
        push_word     = {rd_last_q, ret_byte, pack_q};

        // Returned byte lands in the lane matching its word index modulo 4.
        if (rd_inflight_q) begin
            lane_d = lane_q + 2'd1;
            case (lane_q)
                2'd0:    pack_d[7:0]   = ret_byte;
                2'd1:    pack_d[15:8]  = ret_byte;
                2'd2:    pack_d[23:16] = ret_byte;
                default: pack_d        = pack_q;
            endcase
        end

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
        tvalid_d     = (fifo_count_d != '0);

        // Output register always mirrors the FIFO head after this edge.
        if (pop) begin
            if (fifo_count_q > CNT_W'(1)) head_d = mem_q[rd_ptr_q + PTR_W'(1)];
            else if (push)                head_d = push_word;
        end else if ((fifo_count_q == '0) && push) begin
            head_d = push_word;
        end

        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (start) state_d = gat_ready ? S_READ : S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (gat_ready) state_d = S_READ;
            end
            S_READ: begin
                if (issue) begin
                    if (idx_q == IDX_W'(LAST_IDX)) state_d = S_DRAIN;
                    else                           idx_d   = idx_q + IDX_W'(1);
                end
            end
            S_DRAIN: begin
                if ((fifo_count_d == '0) && !rd_inflight_q && (lane_q == 2'd0)) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            rd_inflight_q <= 1'b0;
            rd_last_q     <= 1'b0;
            lane_q        <= '0;
            pack_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count_q  <= '0;
            tvalid_q      <= 1'b0;
            tdata_q       <= '0;
            tlast_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            rd_inflight_q <= rd_inflight_d;
            rd_last_q     <= rd_last_d;
            lane_q        <= lane_d;
            pack_q        <= pack_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_count_q  <= fifo_count_d;
            tvalid_q      <= tvalid_d;
            {tlast_q, tdata_q} <= head_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Beat storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_word;
    end

    assign bus.feat_bram_addrb = {idx_q, 2'b00};
    assign bus.m_tdata         = tdata_q;
    assign bus.m_tvalid        = tvalid_q;
    assign bus.m_tlast         = tlast_q;
    assign busy                = busy_q;
    assign done                = done_q;
endmodule

// File: doc/gat_feat_reader.md
# gat_feat_reader

Read-back stage that sits directly downstream of the GAT accelerator top. Once the layer reports `gat_ready`, it walks the new-feature BRAM through its byte-addressed port B. It packs four `DATA_WIDTH`-bit features per 32-bit beat and streams the whole frame out on a valid/ready interface toward the DMA. Reads are credit-limited so the output FIFO can never overflow under arbitrary back-pressure.

## Interface
- `NUM_SUBGRAPHS`, 2708, nodes in the output feature matrix
- `NUM_FEATURE_OUT`, 16, features per node
- `DATA_WIDTH`, 8, feature width; must be 8
- `NEW_FEATURE_DEPTH`, `NUM_SUBGRAPHS*NUM_FEATURE_OUT`, feature count; must be a multiple of 4
- `NEW_FEATURE_ADDR_W`, `$clog2(NEW_FEATURE_DEPTH)`, word-index width
- `OUT_FIFO_DEPTH`, 4, output beat FIFO depth; power of 2, ≥2
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `gat_ready`  in  1  level; layer complete, feature BRAM valid
- `start`  in  1  one-cycle request to read out a frame
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse after last beat handshake
- `feat_bram_addrb`  out  `NEW_FEATURE_ADDR_W+2`  byte address `{idx,2'b00}`
- `feat_bram_dout`  in  32  read data; only `[DATA_WIDTH-1:0]` used; latency 1 cycle
- `m_tdata`  out  32  packed features; feature `4k+j` in byte `j`
- `m_tvalid`  out  1  beat valid
- `m_tready`  in  1  sink ready
- `m_tlast`  out  1  high on final beat of frame (`NEW_FEATURE_DEPTH/4`-th)

## Operation
- FSM states: IDLE, WAIT_RDY, READ, DRAIN.
  - IDLE: `start` → READ if `gat_ready`, else WAIT_RDY.
  - WAIT_RDY → READ when `gat_ready`.
  - READ: issue reads until `idx == NEW_FEATURE_DEPTH-1` has been issued → DRAIN.
  - DRAIN: wait until the in-flight read, packer and FIFO are all empty and the last beat has handshaken → pulse `done`, return to IDLE.
- `start` is ignored outside IDLE.
- `gat_ready` is sampled only in IDLE/WAIT_RDY. A drop during READ/DRAIN is ignored.
- Read issue: one word index per cycle, ascending from 0. The issue condition is `fifo_count + pend < OUT_FIFO_DEPTH`.
  - `pend` = 1 if the packer holds ≥1 byte or a read is in flight.
- Packer: a 2-bit lane counter. Returned byte goes to lane `idx%4`. When lane 3 fills, the 32-bit word is pushed to the FIFO the same edge and the lane counter wraps to 0.
- FIFO: push and pop in the same cycle are allowed; count is unchanged.
  - Pop occurs when `m_tvalid && m_tready`.
  - `m_tlast` is carried per entry: set on the beat containing feature `NEW_FEATURE_DEPTH-1`.
- `feat_bram_addrb` holds its last value while stalled. It is 0 in IDLE/WAIT_RDY.
- `busy` = state != IDLE.

## Timing
- All outputs reset to 0. FIFO, packer, index and FSM are cleared.
- `rst` mid-frame aborts immediately: no `done`, no further beats, and the next frame restarts at idx 0.
- `start` sampled at edge E0 with `gat_ready=1`:
  - address 0 is driven in cycle 1, addresses 4/8/12 in cycles 2–4;
  - data returns in cycles 2–5, and the first beat is pushed at the end of cycle 5;
  - `m_tvalid` first asserts in cycle 6.
- With `m_tready` held high: one beat per 4 cycles, no stalls. The last handshake occurs in cycle `NEW_FEATURE_DEPTH+2`, and `done` is high in the following cycle.
- Back-pressure: `m_tdata`/`m_tlast` remain stable while `m_tvalid && !m_tready`. No beat is lost or duplicated.
- WAIT_RDY: when `gat_ready` rises at edge Ek, address 0 is driven in cycle k+1.

## Test plan
- Reset: hold `rst` for 3 cycles with `start=1`.
  - Required: all outputs 0 and `busy=0` throughout.
- Nominal frame: `NUM_SUBGRAPHS=2`, `NUM_FEATURE_OUT=4`, BRAM[i]=i+1, `m_tready=1`.
  - Required: beats 0x04030201 then 0x08070605 (`m_tlast` on the second).
  - Required: first `m_tvalid` in cycle 6 and `done` in cycle 11.
- Back-pressure: default sizes, `m_tready` random 30% high, BRAM[i]=i[7:0].
  - Required: 10832 beats in order, FIFO never over depth, `m_tlast` only on beat 10831, exactly one `done`.
- Gated start: pulse `start` with `gat_ready=0`, raise `gat_ready` 20 cycles later.
  - Required: no address activity before the rise, then a normal frame.
  - Required: a second `start` while busy causes no effect.
- Reset mid-frame: assert `rst` after 3 beats, then restart.
  - Required: no `done` for the aborted frame.
  - Required: the new frame begins at address 0 with the first beat 0x04030201 (nominal sizes).
